// File: rtl/rpn_pkg.sv
// Shared types and instruction-word layout for the RPN calculator controller.
package rpn_pkg;

  localparam int OPC_W   = 4;
  localparam int IMM_LSB = 0;  // imm occupies [DATA_W-1:0], opcode sits directly above it

  typedef enum logic [3:0] {
    OPC_NOP    = 4'h0,
    OPC_PUSH   = 4'h1,
    OPC_PUSHSW = 4'h2,
    OPC_POP    = 4'h3,
    OPC_DUP    = 4'h4,
    OPC_SWAP   = 4'h5,
    OPC_ADD    = 4'h6,
    OPC_SUB    = 4'h7,
    OPC_AND    = 4'h8,
    OPC_OR     = 4'h9,
    OPC_XOR    = 4'hA,
    OPC_ILL_B  = 4'hB,
    OPC_ILL_C  = 4'hC,
    OPC_ILL_D  = 4'hD,
    OPC_JMP    = 4'hE,
    OPC_HALT   = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    STK_NONE = 3'd0,
    STK_PUSH = 3'd1,
    STK_POP  = 3'd2,
    STK_DUP  = 3'd3,
    STK_SWAP = 3'd4,
    STK_BIN  = 3'd5
  } stk_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/rpn_decode.sv
// Combinational decode of one opcode against the current stack depth.
module rpn_decode #(
  parameter int DEPTH = 8,
  parameter int DEP_W = 4
) (
  input  logic [3:0]       opcode,
  input  logic [DEP_W-1:0] depth,
  output logic [2:0]       stk_op,
  output logic [2:0]       alu_op,
  output logic signed [1:0] depth_delta,
  output logic             is_jmp,
  output logic             is_halt,
  output logic             fault
);
  import rpn_pkg::*;

  localparam logic [DEP_W-1:0] FULL = DEP_W'(DEPTH);
  localparam logic [DEP_W-1:0] TWO  = DEP_W'(2);

  logic not_empty, not_full, has_two;

  assign not_empty = (depth != '0);
  assign not_full  = (depth < FULL);
  assign has_two   = (depth >= TWO);

  always_comb begin
    stk_op      = STK_NONE;
    alu_op      = ALU_ADD;
    depth_delta = 2'sb00;
    is_jmp      = 1'b0;
    is_halt     = 1'b0;
    fault       = 1'b0;
    case (opcode)
      OPC_NOP: ;
      OPC_PUSH, OPC_PUSHSW: begin
        if (not_full) begin stk_op = STK_PUSH; depth_delta = 2'sb01; end
        else fault = 1'b1;
      end
      OPC_POP: begin
        if (not_empty) begin stk_op = STK_POP; depth_delta = 2'sb11; end
        else fault = 1'b1;
      end
      OPC_DUP: begin
        if (not_empty && not_full) begin stk_op = STK_DUP; depth_delta = 2'sb01; end
        else fault = 1'b1;
      end
      OPC_SWAP: begin
        if (has_two) stk_op = STK_SWAP;
        else fault = 1'b1;
      end
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR: begin
        if (has_two) begin
          stk_op      = STK_BIN;
          depth_delta = 2'sb11;
          case (opcode)
            OPC_SUB: alu_op = ALU_SUB;
            OPC_AND: alu_op = ALU_AND;
            OPC_OR:  alu_op = ALU_OR;
            OPC_XOR: alu_op = ALU_XOR;
            default: alu_op = ALU_ADD;
          endcase
        end else fault = 1'b1;
      end
      OPC_JMP:  is_jmp  = 1'b1;
      OPC_HALT: is_halt = 1'b1;
      default:  fault   = 1'b1;
    endcase
  end

endmodule

// File: rtl/rpn_ctrl.sv
// RPN calculator sequencer: FETCH/WAIT/EXEC per instruction, one stack command per EXEC.
module rpn_ctrl #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int DEPTH  = 8
) (
  input  logic                         CLOCK_50,
  input  logic                         rst_n,
  input  logic                         step,
  input  logic                         run,
  input  logic [DATA_W-1:0]            sw_data,
  output logic [PC_W-1:0]              mem_addr,
  output logic                         mem_rd,
  input  logic [DATA_W+3:0]            mem_q,
  output logic [2:0]                   stk_op,
  output logic [DATA_W-1:0]            stk_wdata,
  output logic [2:0]                   alu_op,
  output logic [PC_W-1:0]              pc,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         busy,
  output logic                         halted,
  output logic                         error
);
  import rpn_pkg::*;

  localparam int DEP_W = $clog2(DEPTH+1);
  localparam int IW    = OPC_W + DATA_W;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [DEP_W-1:0]   depth_q, depth_d;
  logic [IW-1:0]      instr_q, instr_d;
  logic               halted_q, halted_d, error_q, error_d;

  logic [OPC_W-1:0]   opcode;
  logic [DATA_W-1:0]  imm;
  logic [2:0]         dec_stk_op, dec_alu_op;
  logic signed [1:0]  dec_delta;
  logic               dec_jmp, dec_halt, dec_fault, exec_ok;

  assign opcode = instr_q[DATA_W +: OPC_W];
  assign imm    = instr_q[IMM_LSB +: DATA_W];

  rpn_decode #(.DEPTH(DEPTH), .DEP_W(DEP_W)) u_decode (
    .opcode      (opcode),
    .depth       (depth_q),
    .stk_op      (dec_stk_op),
    .alu_op      (dec_alu_op),
    .depth_delta (dec_delta),
    .is_jmp      (dec_jmp),
    .is_halt     (dec_halt),
    .fault       (dec_fault)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    depth_d  = depth_q;
    instr_d  = instr_q;
    halted_d = halted_q;
    error_d  = error_q;
    case (state_q)
      ST_IDLE:  if (step || run) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        instr_d = mem_q;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // a faulting instruction leaves pc pointing at itself for post-mortem
        if (dec_fault) begin
          state_d = ST_ERR;
          error_d = 1'b1;
        end else if (dec_halt) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          pc_d    = dec_jmp ? PC_W'(imm) : pc_q + PC_W'(1);
          if (dec_delta == 2'sb01)      depth_d = depth_q + DEP_W'(1);
          else if (dec_delta == 2'sb11) depth_d = depth_q - DEP_W'(1);
        end
      end
      ST_HALT, ST_ERR: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      depth_q  <= '0;
      instr_q  <= '0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      depth_q  <= depth_d;
      instr_q  <= instr_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  // Commands are decoded from state, so a reset mid-instruction drops them immediately.
  assign exec_ok   = (state_q == ST_EXEC) && !dec_fault;
  assign mem_rd    = (state_q == ST_FETCH);
  assign mem_addr  = pc_q;
  assign stk_op    = exec_ok ? dec_stk_op : STK_NONE;
  assign alu_op    = (exec_ok && dec_stk_op == STK_BIN) ? dec_alu_op : ALU_ADD;
  assign stk_wdata = (exec_ok && dec_stk_op == STK_PUSH) ?
                     ((opcode == OPC_PUSHSW) ? sw_data : imm) : '0;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_EXEC);
  assign pc        = pc_q;
  assign depth     = depth_q;
  assign halted    = halted_q;
  assign error     = error_q;

endmodule

// File: tb/tb_rpn_ctrl.sv
// Directed bench for rpn_ctrl with a behavioural one-cycle-latency program memory.
module tb_rpn_ctrl;
  import rpn_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  sw_data = 8'h00;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [11:0] mem_q = 12'h000;
  logic [2:0]  stk_op;
  logic [7:0]  stk_wdata;
  logic [2:0]  alu_op;
  logic [7:0]  pc;
  logic [3:0]  depth;
  logic        busy, halted, error;

  int checks = 0;
  int errors = 0;

  logic [11:0] prog [256];
  int n_rd = 0, n_push = 0, n_bin = 0, n_any = 0;
  logic [7:0] last_wdata = 8'h00;
  logic [2:0] last_alu = 3'd0;

  rpn_ctrl #(.DATA_W(8), .PC_W(8), .DEPTH(8)) dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .step     (step),
    .run      (run),
    .sw_data  (sw_data),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_q    (mem_q),
    .stk_op   (stk_op),
    .stk_wdata(stk_wdata),
    .alu_op   (alu_op),
    .pc       (pc),
    .depth    (depth),
    .busy     (busy),
    .halted   (halted),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_q <= prog[mem_addr];

  always @(negedge clk) begin
    if (mem_rd) n_rd++;
    if (stk_op != STK_NONE) n_any++;
    if (stk_op == STK_PUSH) begin n_push++; last_wdata = stk_wdata; end
    if (stk_op == STK_BIN) begin n_bin++; last_alu = alu_op; end
  end

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = ins(OPC_NOP, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step = 1'b0; run = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic test_reset();
    int rd0;
    rst_n = 1'b0; run = 1'b1; step = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rst_hold_pc got %0h want 0", pc); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_hold_rd got %0b want 0", mem_rd); end
    run = 1'b0; step = 1'b0; rst_n = 1'b1;
    rd0 = n_rd;
    repeat (10) @(negedge clk);
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rst_pc got %0h want 0", pc); end
    checks++; if (depth !== 4'd0) begin errors++; $display("FAIL rst_depth got %0d want 0", depth); end
    checks++; if ({busy, halted, error} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {busy, halted, error}); end
    checks++; if (stk_op !== STK_NONE || stk_wdata !== 8'h00 || alu_op !== ALU_ADD) begin
      errors++; $display("FAIL rst_cmd got op %0d wd %0h alu %0d want 0 0 0", stk_op, stk_wdata, alu_op); end
    checks++; if (n_rd - rd0 !== 0) begin errors++; $display("FAIL rst_idle_rd got %0d want 0", n_rd - rd0); end
  endtask

  task automatic test_push_sub();
    int bin0;
    clear_prog();
    prog[0] = ins(OPC_PUSH, 8'h05); prog[1] = ins(OPC_PUSH, 8'h03); prog[2] = ins(OPC_SUB, 8'h00);
    do_reset();
    pulse_step();
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("FAIL fetch rd %0b addr %0h want 1 0", mem_rd, mem_addr); end
    @(negedge clk);
    checks++; if (mem_rd !== 1'b0 || stk_op !== STK_NONE) begin errors++; $display("FAIL wait rd %0b op %0d want 0 0", mem_rd, stk_op); end
    @(negedge clk);
    checks++; if (stk_op !== STK_PUSH || stk_wdata !== 8'h05) begin errors++; $display("FAIL exec_push op %0d wd %0h want 1 05", stk_op, stk_wdata); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL exec_pc_early got %0h want 0", pc); end
    @(negedge clk);
    checks++; if (pc !== 8'h01 || depth !== 4'd1) begin errors++; $display("FAIL push1 pc %0h depth %0d want 1 1", pc, depth); end
    checks++; if (stk_op !== STK_NONE || busy !== 1'b0) begin errors++; $display("FAIL push1_idle op %0d busy %0b want 0 0", stk_op, busy); end
    pulse_step(); repeat (3) @(negedge clk);
    checks++; if (pc !== 8'h02 || depth !== 4'd2) begin errors++; $display("FAIL push2 pc %0h depth %0d want 2 2", pc, depth); end
    bin0 = n_bin;
    pulse_step(); repeat (3) @(negedge clk);
    checks++; if (pc !== 8'h03 || depth !== 4'd1) begin errors++; $display("FAIL sub pc %0h depth %0d want 3 1", pc, depth); end
    checks++; if (n_bin - bin0 !== 1 || last_alu !== ALU_SUB) begin errors++; $display("FAIL sub_bin count %0d alu %0d want 1 1", n_bin - bin0, last_alu); end
  endtask

  task automatic test_run_halt();
    int push0;
    clear_prog();
    prog[0] = ins(OPC_PUSHSW, 8'h00); prog[1] = ins(OPC_DUP, 8'h00);
    prog[2] = ins(OPC_ADD, 8'h00);    prog[3] = ins(OPC_HALT, 8'h00);
    sw_data = 8'hA9;
    do_reset();
    push0 = n_push;
    run = 1'b1;
    for (int i = 0; i < 60 && !halted; i++) @(negedge clk);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL run_halted got %0b want 1", halted); end
    checks++; if (pc !== 8'h03 || depth !== 4'd1 || error !== 1'b0) begin errors++; $display("FAIL run_end pc %0h depth %0d err %0b want 3 1 0", pc, depth, error); end
    checks++; if (n_push - push0 !== 1 || last_wdata !== 8'hA9) begin errors++; $display("FAIL run_pushsw count %0d wd %0h want 1 a9", n_push - push0, last_wdata); end
    run = 1'b0;
    pulse_step(); repeat (3) @(negedge clk);
    pulse_step(); repeat (3) @(negedge clk);
    checks++; if (pc !== 8'h03 || busy !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_sticky pc %0h busy %0b halted %0b want 3 0 1", pc, busy, halted); end
  endtask

  task automatic test_underflow();
    int any0, rd0;
    clear_prog();
    prog[0] = ins(OPC_POP, 8'h00);
    do_reset();
    any0 = n_any; rd0 = n_rd;
    pulse_step(); repeat (3) @(negedge clk);
    checks++; if (error !== 1'b1 || pc !== 8'h00 || depth !== 4'd0) begin errors++; $display("FAIL uflow err %0b pc %0h depth %0d want 1 0 0", error, pc, depth); end
    checks++; if (n_any - any0 !== 0) begin errors++; $display("FAIL uflow_cmd got %0d want 0", n_any - any0); end
    pulse_step(); repeat (3) @(negedge clk);
    checks++; if (n_rd - rd0 !== 1 || pc !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL err_sticky fetches %0d pc %0h busy %0b want 1 0 0", n_rd - rd0, pc, busy); end
    do_reset();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", error); end
  endtask

  task automatic test_jmp_wrap();
    clear_prog();
    prog[0] = ins(OPC_JMP, 8'hFE);
    do_reset();
    pulse_step(); repeat (3) @(negedge clk);
    checks++; if (pc !== 8'hFE) begin errors++; $display("FAIL jmp got %0h want fe", pc); end
    pulse_step(); repeat (3) @(negedge clk);
    checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL nop_fe got %0h want ff", pc); end
    pulse_step(); repeat (3) @(negedge clk);
    checks++; if (pc !== 8'h00 || depth !== 4'd0) begin errors++; $display("FAIL wrap pc %0h depth %0d want 0 0", pc, depth); end
  endtask

  task automatic test_overflow();
    int push0;
    clear_prog();
    for (int i = 0; i < 9; i++) prog[i] = ins(OPC_PUSH, 8'(i + 16));
    do_reset();
    push0 = n_push;
    run = 1'b1;
    for (int i = 0; i < 80 && !error; i++) @(negedge clk);
    run = 1'b0;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL oflow_err got %0b want 1", error); end
    checks++; if (depth !== 4'd8 || pc !== 8'h08) begin errors++; $display("FAIL oflow depth %0d pc %0h want 8 08", depth, pc); end
    checks++; if (n_push - push0 !== 8) begin errors++; $display("FAIL oflow_pushes got %0d want 8", n_push - push0); end
  endtask

  task automatic test_back_to_back();
    int rd0;
    clear_prog();
    prog[0] = ins(OPC_PUSH, 8'h11); prog[1] = ins(OPC_PUSH, 8'h22);
    do_reset();
    rd0 = n_rd;
    pulse_step();
    pulse_step(); pulse_step(); pulse_step();
    repeat (5) @(negedge clk);
    checks++; if (pc !== 8'h01 || depth !== 4'd1) begin errors++; $display("FAIL busy_step pc %0h depth %0d want 1 1", pc, depth); end
    checks++; if (n_rd - rd0 !== 1 || last_wdata !== 8'h11) begin errors++; $display("FAIL busy_fetch count %0d wd %0h want 1 11", n_rd - rd0, last_wdata); end
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_push_sub();
    test_run_halt();
    test_underflow();
    test_jmp_wrap();
    test_overflow();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpn_ctrl.md
Name: rpn_ctrl

Overview:
- Sequencing controller for the RPN calculator datapath.
- Fetches one instruction per step from the synchronous program memory at PC and decodes it.
- Issues a single stack/ALU command per instruction, tracks stack depth, and advances PC.
- Sits between the top level (KEY/SW inputs) and the stack, ALU and program memory.

Parameters:
- DATA_W, 8, operand/immediate width.
- PC_W, 8, program counter / memory address width.
- DEPTH, 8, stack capacity in entries (≥2).

Ports:
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset; top level drives it from KEY[3].
- step  in  1  one-cycle pulse, already synchronised and edge-detected from KEY[0]; requests one instruction.
- run  in  1  level, from SW[9]; when high, instructions execute back to back.
- sw_data  in  DATA_W  switch operand for PUSHSW.
- mem_addr  out  PC_W  program memory address; equals pc.
- mem_rd  out  1  read strobe, high in FETCH only.
- mem_q  in  4+DATA_W  instruction word, valid one cycle after mem_rd; [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] imm.
- stk_op  out  3  stack command for this cycle; NONE/PUSH/POP/DUP/SWAP/BIN; valid in EXEC only, NONE elsewhere.
- stk_wdata  out  DATA_W  push data (imm or sw_data); 0 when not PUSH.
- alu_op  out  3  ADD/SUB/AND/OR/XOR; meaningful only with stk_op=BIN.
- pc  out  PC_W  program counter.
- depth  out  $clog2(DEPTH+1)  current stack occupancy.
- busy  out  1  high in FETCH, WAIT, EXEC.
- halted  out  1  sticky, set by HALT.
- error  out  1  sticky, set by illegal opcode, overflow or underflow.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, pc=0, depth=0, halted=0, error=0, mem_rd=0, stk_op=NONE, stk_wdata=0, alu_op=ADD.
  - Reset mid-instruction aborts with no stack command issued.
  - While rst_n is held low, pc stays 0.
- FSM states: IDLE, FETCH, WAIT, EXEC, HALT, ERR.
  - IDLE → FETCH when step=1 or run=1; otherwise stay. pc stays unchanged with no step and run=0.
  - FETCH: mem_rd=1, mem_addr=pc → WAIT.
  - WAIT: memory latency cycle → EXEC; instruction is registered from mem_q at the end of WAIT.
  - EXEC: decode, drive stk_op/alu_op/stk_wdata for exactly one cycle, update pc and depth → IDLE, HALT or ERR.
- Latency: step sampled at edge k gives FETCH after k, EXEC after k+2, and the new pc visible after edge k+3. In run mode each instruction takes 4 cycles.
- step pulses arriving while busy, HALT or ERR are ignored; there is no queueing.
- Opcodes, with the depth precondition and effect of each:
  - 0 NOP: none; no stack op.
  - 1 PUSH imm: needs depth<DEPTH; depth+1.
  - 2 PUSHSW: needs depth<DEPTH; pushes sw_data; depth+1.
  - 3 POP: needs depth≥1; depth−1.
  - 4 DUP: needs 1≤depth<DEPTH; depth+1.
  - 5 SWAP: needs depth≥2; depth unchanged.
  - 6 ADD, 7 SUB, 8 AND, 9 OR, A XOR: stk_op=BIN; datapath pops tos and nos and pushes nos op tos. SUB is nos−tos. Needs depth≥2; depth−1.
  - E JMP imm: pc ← imm[PC_W-1:0]; no stack op.
  - F HALT: set halted, → HALT; pc not incremented.
  - B, C, D: illegal.
- A failed precondition or illegal opcode sets error and goes to ERR. In that case stk_op=NONE, and pc and depth are unchanged (pc points at the faulting instruction).
- pc increment wraps modulo 2^PC_W, from 255 to 0 at the default width. Data arithmetic is owned by the ALU and wraps modulo 2^DATA_W.
- HALT and ERR are absorbing until reset.

Decomposition:
- Package rpn_pkg holds:
  - opcode enum (4-bit) and stk_op_t enum (3-bit);
  - alu_op_t enum (3-bit) and state_t enum;
  - field-position constants for the instruction word.
- Sub-module rpn_decode: combinational opcode plus depth → {stk_op, alu_op, depth_delta, is_jmp, is_halt, fault}. The FSM and registers stay in rpn_ctrl.

Test Plan:
- Hold rst_n=0 for 4 cycles, then release with step=0 and run=0 for 10 cycles → pc=0, depth=0, state IDLE, mem_rd never high.
- Program [PUSH 0x05, PUSH 0x03, SUB]; one step pulse → pc=1 exactly 3 cycles after the pulse edge, stk_op=PUSH and stk_wdata=0x05 for one cycle. Two more steps → depth=1; stk_op=BIN, alu_op=SUB seen once.
- run=1, program [PUSHSW, DUP, ADD, HALT] with sw_data=0xA9 → stk_wdata=0xA9 on the first push. Final pc=3, depth=1, halted=1; further steps leave pc=3.
- Program [POP] at depth 0 → error=1, pc=0, stk_op stays NONE; step ignored until reset; reset clears error.
- Program pc=0: JMP 0xFE; at 0xFE NOP, 0xFF NOP → pc sequence 0→0xFE→0xFF→0x00 (wrap).
- DEPTH+1 consecutive PUSH → depth saturates at 8, the 9th push sets error with pc=8. Separately, a step pulse during busy is ignored: exactly one instruction executes.
